// File: rtl/jts16_ba_responder.sv
// jts16_ba_responder
// Target end of the 4-bank SDRAM request interface used by the S16 memory map.
// Bank requesters raise ba_rd / ba_wr. This block arbitrates them onto one
// in-order memory backend and answers each bank with ack/dst/dok/rdy.
// Read bursts of BURST words are serialised onto data_read. Only one
// transaction is in flight at a time.
//
// Configuration macro:
//   JTS16_BA_RR_EN  defined   : round-robin arbitration. The pointer moves to
//                               the bank after the winner on every ack.
//                   undefined : fixed priority, bank0 > bank1 > bank2 > bank3.
//
// Parameters:
//   BURST  words per read transaction (1..4)
//   AW     per-bank word address width
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ba0..ba3_addr   in  AW     per-bank word address
//   ba_rd           in  4      read request per bank, held until ack
//   ba_wr           in  1      bank-0 write request, held until ack
//   ba0_din/_m      in  16/2   bank-0 write data / mask (1 = byte kept)
//   ba_ack          out 4      request accepted (pulses on the first grant)
//   ba_dst          out 4      first read word on data_read
//   ba_dok          out 4      data_read valid for this bank
//   ba_rdy          out 4      transaction complete
//   data_read       out 16     read data shared by all banks
//   mem_req/gnt     out/in     backend word request / accept
//   mem_we          out        request is a write
//   mem_addr        out AW+2   {bank, word address}
//   mem_wdata/wmask out 16/2   write data / mask
//   mem_rdata       in  16     read data
//   mem_rvalid      in  1      read data valid, in request order
module jts16_ba_responder #(
  parameter int BURST = 2,
  parameter int AW    = 22
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ba0_addr,
  input  logic [AW-1:0] ba1_addr,
  input  logic [AW-1:0] ba2_addr,
  input  logic [AW-1:0] ba3_addr,
  input  logic [3:0]    ba_rd,
  input  logic          ba_wr,
  input  logic [15:0]   ba0_din,
  input  logic [1:0]    ba0_din_m,
  output logic [3:0]    ba_ack,
  output logic [3:0]    ba_dst,
  output logic [3:0]    ba_dok,
  output logic [3:0]    ba_rdy,
  output logic [15:0]   data_read,
  output logic          mem_req,
  input  logic          mem_gnt,
  output logic          mem_we,
  output logic [AW+1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic [1:0]    mem_wmask,
  input  logic [15:0]   mem_rdata,
  input  logic          mem_rvalid
);

  localparam logic [2:0] BURST_C = 3'(BURST);
  localparam logic [2:0] LAST_C  = 3'(BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [1:0]    bank_r;
  logic [AW-1:0] addr_r;
  logic          we_r;
  logic [15:0]   wdata_r;
  logic [1:0]    wmask_r;
  logic [2:0]    issued_r;
  logic [2:0]    recv_r;

  logic [3:0]    req_s;
  logic          any_req_s;
  logic [1:0]    win_s;
  logic [AW-1:0] sel_addr_s;
  logic          gnt_s;
  logic          first_gnt_s;
  logic          rd_acc_s;
  logic          rd_last_s;

  function automatic logic [3:0] bank_onehot(input logic [1:0] bank);
    case (bank)
      2'd0:    bank_onehot = 4'b0001;
      2'd1:    bank_onehot = 4'b0010;
      2'd2:    bank_onehot = 4'b0100;
      2'd3:    bank_onehot = 4'b1000;
      default: bank_onehot = 4'b0000;
    endcase
  endfunction

  assign req_s       = {ba_rd[3:1], ba_rd[0] | ba_wr};
  assign any_req_s   = |req_s;
  assign gnt_s       = (state_r == ST_ISSUE) && mem_gnt;
  assign first_gnt_s = gnt_s && (issued_r == 3'd0);
  // A read word is only accepted while our read is open and not yet full.
  // Stray rvalid pulses (e.g. left over from a burst cut by reset) are dropped.
  assign rd_acc_s    = mem_rvalid && !we_r && (recv_r < BURST_C) &&
                       ((state_r == ST_ISSUE) || (state_r == ST_WAIT));
  assign rd_last_s   = rd_acc_s && (recv_r == LAST_C);

`ifdef JTS16_BA_RR_EN
  logic [1:0] rr_ptr_r;
  logic [1:0] rr_idx_s;
  logic       rr_found_s;

  // Round-robin winner: first requesting bank at or after the pointer.
  always_comb begin
    win_s      = 2'd0;
    rr_found_s = 1'b0;
    rr_idx_s   = rr_ptr_r;
    for (int i = 0; i < 4; i++) begin
      rr_idx_s = rr_ptr_r + 2'(i);
      if (!rr_found_s && req_s[rr_idx_s]) begin
        win_s      = rr_idx_s;
        rr_found_s = 1'b1;
      end else begin
        win_s = win_s;
      end
    end
  end

  // Round-robin pointer moves past the bank that was just acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= 2'd0;
    end else if (first_gnt_s) begin
      rr_ptr_r <= bank_r + 2'd1;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`else
  // Fixed-priority winner; bank0 carries the CPU and gets the lowest latency.
  always_comb begin
    if (req_s[0]) begin
      win_s = 2'd0;
    end else if (req_s[1]) begin
      win_s = 2'd1;
    end else if (req_s[2]) begin
      win_s = 2'd2;
    end else begin
      win_s = 2'd3;
    end
  end
`endif

  // Address of the winning bank.
  always_comb begin
    case (win_s)
      2'd0:    sel_addr_s = ba0_addr;
      2'd1:    sel_addr_s = ba1_addr;
      2'd2:    sel_addr_s = ba2_addr;
      2'd3:    sel_addr_s = ba3_addr;
      default: sel_addr_s = ba0_addr;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // A zero-latency backend may return the last word together with the last grant.
        if (rd_last_s) begin
          state_s = ST_IDLE;
        end else if (mem_gnt && we_r) begin
          state_s = ST_DONE;
        end else if (mem_gnt && (issued_r == LAST_C)) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (rd_last_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Backend request outputs and ack. The ack follows mem_gnt in the same cycle.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {(AW + 2){1'b0}};
    mem_wdata = 16'h0000;
    mem_wmask = 2'b00;
    ba_ack    = 4'b0000;
    case (state_r)
      ST_ISSUE: begin
        mem_req  = 1'b1;
        mem_we   = we_r;
        // The word address wraps inside the bank and never carries into the bank bits.
        mem_addr = {bank_r, addr_r + AW'(issued_r)};
        if (we_r) begin
          mem_wdata = wdata_r;
          mem_wmask = wmask_r;
        end else begin
          mem_wdata = 16'h0000;
          mem_wmask = 2'b00;
        end
        if (first_gnt_s) begin
          ba_ack = bank_onehot(bank_r);
        end else begin
          ba_ack = 4'b0000;
        end
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // Transaction latch plus issued / received word counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_r   <= 2'd0;
      addr_r   <= {AW{1'b0}};
      we_r     <= 1'b0;
      wdata_r  <= 16'h0000;
      wmask_r  <= 2'b00;
      issued_r <= 3'd0;
      recv_r   <= 3'd0;
    end else if ((state_r == ST_IDLE) && any_req_s) begin
      bank_r   <= win_s;
      addr_r   <= sel_addr_s;
      we_r     <= ba_wr && (win_s == 2'd0);
      wdata_r  <= ba0_din;
      wmask_r  <= ba0_din_m;
      issued_r <= 3'd0;
      recv_r   <= 3'd0;
    end else begin
      if (gnt_s) begin
        issued_r <= issued_r + 3'd1;
      end
      if (rd_acc_s) begin
        recv_r <= recv_r + 3'd1;
      end
    end
  end

  // Registered responses to the banks: dst/dok/rdy pulses and the data_read hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_read <= 16'h0000;
      ba_dst    <= 4'b0000;
      ba_dok    <= 4'b0000;
      ba_rdy    <= 4'b0000;
    end else begin
      ba_dst <= 4'b0000;
      ba_dok <= 4'b0000;
      ba_rdy <= 4'b0000;
      if (rd_acc_s) begin
        data_read <= mem_rdata;
        ba_dok    <= bank_onehot(bank_r);
        ba_dst    <= (recv_r == 3'd0) ? bank_onehot(bank_r) : 4'b0000;
        ba_rdy    <= rd_last_s ? bank_onehot(bank_r) : 4'b0000;
      end else if (gnt_s && we_r) begin
        // A write completes in the DONE cycle right after its grant.
        ba_rdy <= 4'b0001;
      end else begin
        data_read <= data_read;
      end
    end
  end

endmodule
